// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee vending controller.
package coffee_pkg;

    localparam int COIN_W = 4;
    localparam logic [COIN_W-1:0] COIN_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_BREW,
        ST_PAYOUT
    } state_t;

    localparam logic [2:0] SEL_ESPRESSO   = 3'd1;
    localparam logic [2:0] SEL_MILK       = 3'd2;
    localparam logic [2:0] SEL_CAPPUCCINO = 3'd3;
    localparam logic [2:0] SEL_MOCHACCINO = 3'd4;

    localparam logic [COIN_W-1:0] PRICE_ESPRESSO   = 4'd3;
    localparam logic [COIN_W-1:0] PRICE_MILK       = 4'd4;
    localparam logic [COIN_W-1:0] PRICE_CAPPUCCINO = 4'd5;
    localparam logic [COIN_W-1:0] PRICE_MOCHACCINO = 4'd7;

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel >= SEL_ESPRESSO) && (sel <= SEL_MOCHACCINO);
    endfunction

    // Price lookup for the change unit side; 0 marks an invalid code.
    function automatic logic [COIN_W-1:0] price_of(input logic [2:0] sel);
        case (sel)
            SEL_ESPRESSO:   return PRICE_ESPRESSO;
            SEL_MILK:       return PRICE_MILK;
            SEL_CAPPUCCINO: return PRICE_CAPPUCCINO;
            SEL_MOCHACCINO: return PRICE_MOCHACCINO;
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/coin_counter.sv
// Saturating coin accumulator; clear wins over load, load wins over inc.
module coin_counter
    import coffee_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clear,
    input  logic              load,
    input  logic [COIN_W-1:0] load_val,
    output logic [COIN_W-1:0] count,
    output logic              sat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == COIN_MAX);

endmodule

// File: rtl/coffee_vending_controller.sv
// Coffee vending sequencer: coin collection, change-unit handshake, brew timer, coin payout.
//   state   | meaning
//   IDLE    | no credit, waiting for the first coin
//   COLLECT | accumulating coins, accepting confirm/cancel
//   CHECK   | one-cycle query of the external change unit
//   BREW    | brew timer running
//   PAYOUT  | returning change/refund one coin per two cycles
module coffee_vending_controller
    import coffee_pkg::*;
#(
    parameter int BREW_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_in,
    input  logic [2:0]        coffee_sel,
    input  logic              confirm,
    input  logic              cancel,
    input  logic [COIN_W-1:0] sub_change,
    input  logic              sub_enable,
    output logic [COIN_W-1:0] total_coins,
    output logic [2:0]        coffee_type,
    output logic              sub_confirm,
    output logic              brewing,
    output logic              dispense,
    output logic              change_pulse,
    output logic              coin_reject,
    output logic              insufficient,
    output logic              busy
);

    localparam logic [7:0] BREW_LOAD = 8'(BREW_CYCLES);

    state_t            state, state_nxt;
    logic [7:0]        brew_cnt, brew_cnt_nxt;
    logic [COIN_W-1:0] payout_cnt, payout_nxt;
    logic [2:0]        coffee_type_nxt;
    logic              dispense_nxt, change_nxt, reject_nxt, insuff_nxt;
    logic              cc_inc, cc_clear, cc_load, cc_sat;

    coin_counter u_coin_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (cc_inc),
        .clear    (cc_clear),
        .load     (cc_load),
        .load_val (4'd1),
        .count    (total_coins),
        .sat      (cc_sat)
    );

    always_comb begin
        state_nxt       = state;
        brew_cnt_nxt    = brew_cnt;
        payout_nxt      = payout_cnt;
        coffee_type_nxt = coffee_type;
        dispense_nxt    = 1'b0;
        change_nxt      = 1'b0;
        reject_nxt      = 1'b0;
        insuff_nxt      = 1'b0;
        cc_inc          = 1'b0;
        cc_clear        = 1'b0;
        cc_load         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (coin_in) begin
                    cc_load   = 1'b1;
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A coin dropped together with cancel is not credited, so hand it back.
                if (cancel) begin
                    payout_nxt = total_coins;
                    reject_nxt = coin_in;
                    state_nxt  = ST_PAYOUT;
                end else if (coin_in) begin
                    if (cc_sat) reject_nxt = 1'b1;
                    else        cc_inc     = 1'b1;
                end else if (confirm) begin
                    if (sel_valid(coffee_sel)) begin
                        coffee_type_nxt = coffee_sel;
                        state_nxt       = ST_CHECK;
                    end else begin
                        insuff_nxt = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                reject_nxt = coin_in;
                if (sub_enable) begin
                    payout_nxt   = sub_change;
                    cc_clear     = 1'b1;
                    brew_cnt_nxt = BREW_LOAD;
                    state_nxt    = ST_BREW;
                end else begin
                    insuff_nxt = 1'b1;
                    state_nxt  = ST_COLLECT;
                end
            end
            ST_BREW: begin
                reject_nxt = coin_in;
                if (brew_cnt <= 8'd1) begin
                    brew_cnt_nxt = '0;
                    dispense_nxt = 1'b1;
                    state_nxt    = (payout_cnt != '0) ? ST_PAYOUT : ST_IDLE;
                end else begin
                    brew_cnt_nxt = brew_cnt - 8'd1;
                end
            end
            ST_PAYOUT: begin
                reject_nxt = coin_in;
                // change_pulse doubles as the high/low phase of each returned coin.
                if (payout_cnt == '0) begin
                    cc_clear  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!change_pulse) begin
                    change_nxt = 1'b1;
                    payout_nxt = payout_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            brew_cnt     <= '0;
            payout_cnt   <= '0;
            coffee_type  <= '0;
            sub_confirm  <= 1'b0;
            brewing      <= 1'b0;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            brew_cnt     <= brew_cnt_nxt;
            payout_cnt   <= payout_nxt;
            coffee_type  <= coffee_type_nxt;
            sub_confirm  <= (state_nxt == ST_CHECK);
            brewing      <= (state_nxt == ST_BREW);
            dispense     <= dispense_nxt;
            change_pulse <= change_nxt;
            coin_reject  <= reject_nxt;
            insufficient <= insuff_nxt;
            busy         <= (state_nxt != ST_IDLE) && (state_nxt != ST_COLLECT);
        end
    end

endmodule

// File: tb/tb_coffee_vending_controller.sv
// Directed bench for coffee_vending_controller; the external change unit is stubbed by driven inputs.
module tb_coffee_vending_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_in, confirm, cancel, sub_enable;
    logic [2:0] coffee_sel;
    logic [3:0] sub_change;
    logic [3:0] total_coins;
    logic [2:0] coffee_type;
    logic       sub_confirm, brewing, dispense, change_pulse, coin_reject, insufficient, busy;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int n_sc = 0, n_brew = 0, n_disp = 0, n_chg = 0, n_rej = 0, n_ins = 0;
    int brew_last = -1, disp_last = -1, chg_last = -1;
    int b_sc, b_brew, b_disp, b_chg, b_rej, b_ins;

    always #5 clk = ~clk;

    coffee_vending_controller #(.BREW_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_in      (coin_in),
        .coffee_sel   (coffee_sel),
        .confirm      (confirm),
        .cancel       (cancel),
        .sub_change   (sub_change),
        .sub_enable   (sub_enable),
        .total_coins  (total_coins),
        .coffee_type  (coffee_type),
        .sub_confirm  (sub_confirm),
        .brewing      (brewing),
        .dispense     (dispense),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .insufficient (insufficient),
        .busy         (busy)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sub_confirm)  n_sc   <= n_sc + 1;
        if (brewing)      begin n_brew <= n_brew + 1; brew_last <= cyc; end
        if (dispense)     begin n_disp <= n_disp + 1; disp_last <= cyc; end
        if (change_pulse) begin n_chg  <= n_chg + 1;  chg_last  <= cyc; end
        if (coin_reject)  n_rej  <= n_rej + 1;
        if (insufficient) n_ins  <= n_ins + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic mark();
        b_sc = n_sc; b_brew = n_brew; b_disp = n_disp;
        b_chg = n_chg; b_rej = n_rej; b_ins = n_ins;
    endtask

    task automatic coins(input int n);
        coin_in = 1'b1;
        cycles(n);
        coin_in = 1'b0;
    endtask

    task automatic do_confirm();
        confirm = 1'b1;
        cycles(1);
        confirm = 1'b0;
    endtask

    task automatic wait_brewing(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (brewing) begin
                seen = 1'b1;
                break;
            end
            cycles(1);
        end
        check_val(tag, int'(seen), 1);
    endtask

    initial begin
        rst = 1'b1;
        coin_in = 1'b0; confirm = 1'b0; cancel = 1'b0;
        sub_enable = 1'b0; sub_change = 4'd0; coffee_sel = 3'd0;
        cycles(3);
        check_val("rst_total", int'(total_coins), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_brewing", int'(brewing), 0);
        check_val("rst_sub_confirm", int'(sub_confirm), 0);
        rst = 1'b0;
        // Confirm/cancel in IDLE must do nothing.
        confirm = 1'b1; cancel = 1'b1; coffee_sel = 3'd1;
        cycles(2);
        confirm = 1'b0; cancel = 1'b0;
        check_val("idle_ignore_busy", int'(busy), 0);
        check_val("idle_ignore_total", int'(total_coins), 0);

        // 5 coins, cappuccino, change unit returns 2.
        mark();
        sub_enable = 1'b1; sub_change = 4'd2; coffee_sel = 3'd3;
        coins(5);
        check_val("t1_total", int'(total_coins), 5);
        do_confirm();
        check_val("t1_sub_confirm", int'(sub_confirm), 1);
        check_val("t1_coffee_type", int'(coffee_type), 3);
        cycles(30);
        check_val("t1_sc_cycles", n_sc - b_sc, 1);
        check_val("t1_brew_cycles", n_brew - b_brew, 8);
        check_val("t1_dispense", n_disp - b_disp, 1);
        check_val("t1_disp_after_brew", disp_last - brew_last, 1);
        check_val("t1_change", n_chg - b_chg, 2);
        check_val("t1_change_after_disp", int'(chg_last > disp_last), 1);
        check_val("t1_end_busy", int'(busy), 0);
        check_val("t1_end_total", int'(total_coins), 0);

        // 2 coins, mochaccino, funds refused.
        mark();
        sub_enable = 1'b0; coffee_sel = 3'd4;
        coins(2);
        do_confirm();
        cycles(3);
        check_val("t2_insufficient", n_ins - b_ins, 1);
        check_val("t2_busy_collect", int'(busy), 0);
        check_val("t2_total", int'(total_coins), 2);
        coffee_sel = 3'd0;
        do_confirm();
        cycles(2);
        check_val("t2_invalid_sel_ins", n_ins - b_ins, 2);
        check_val("t2_invalid_no_sc", n_sc - b_sc, 1);
        check_val("t2_invalid_total", int'(total_coins), 2);
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
        cycles(10);
        check_val("t2_refund", n_chg - b_chg, 2);
        check_val("t2_end_total", int'(total_coins), 0);

        // 16 coins saturate at 15 with one reject, then full refund.
        mark();
        coins(16);
        cycles(1);
        check_val("t3_total_sat", int'(total_coins), 15);
        check_val("t3_reject", n_rej - b_rej, 1);
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
        cycles(40);
        check_val("t3_refund", n_chg - b_chg, 15);
        check_val("t3_end_busy", int'(busy), 0);

        // Cancel beats confirm in the same cycle.
        mark();
        sub_enable = 1'b1; sub_change = 4'd0; coffee_sel = 3'd1;
        coins(3);
        cancel = 1'b1; confirm = 1'b1;
        cycles(1);
        cancel = 1'b0; confirm = 1'b0;
        cycles(12);
        check_val("t4_refund", n_chg - b_chg, 3);
        check_val("t4_no_sc", n_sc - b_sc, 0);
        check_val("t4_no_disp", n_disp - b_disp, 0);

        // Reset in brew cycle 4.
        sub_enable = 1'b1; sub_change = 4'd3; coffee_sel = 3'd1;
        coins(4);
        do_confirm();
        wait_brewing("t5_brew_seen");
        cycles(3);
        check_val("t5_still_brewing", int'(brewing), 1);
        #2 rst = 1'b1;
        #1;
        check_val("t5_rst_brewing", int'(brewing), 0);
        check_val("t5_rst_busy", int'(busy), 0);
        check_val("t5_rst_type", int'(coffee_type), 0);
        check_val("t5_rst_total", int'(total_coins), 0);
        check_val("t5_rst_pulses", int'({dispense, change_pulse, coin_reject, insufficient, sub_confirm}), 0);
        cycles(2);
        mark();
        rst = 1'b0;
        cycles(25);
        check_val("t5_no_disp", n_disp - b_disp, 0);
        check_val("t5_no_change", n_chg - b_chg, 0);
        coins(1);
        check_val("t5_first_coin", int'(total_coins), 1);
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
        cycles(6);

        // Coins during brew are rejected and do not touch the payout.
        mark();
        sub_enable = 1'b1; sub_change = 4'd2; coffee_sel = 3'd2;
        coins(6);
        do_confirm();
        wait_brewing("t6_brew_seen");
        for (int i = 0; i < 3; i++) begin
            coins(1);
            cycles(1);
        end
        check_val("t6_total_brew", int'(total_coins), 0);
        cycles(25);
        check_val("t6_reject", n_rej - b_rej, 3);
        check_val("t6_dispense", n_disp - b_disp, 1);
        check_val("t6_change", n_chg - b_chg, 2);
        check_val("t6_end_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coffee_vending_controller.md
COFFEE_VENDING_CONTROLLER -- requirements
Module: coffee_vending_controller

Interface
REQ-001 SHALL have parameter BREW_CYCLES, default 8, brewing duration in clock cycles (range 1..255).
REQ-002 SHALL have ports:
  - clk  in  1  rising-edge clock.
  - rst  in  1  asynchronous, active-high reset.
  - coin_in  in  1  one coin per cycle while high.
  - coffee_sel  in  3  1=espresso, 2=coffee and milk, 3=cappuccino, 4=mochaccino; other codes invalid.
  - confirm  in  1  purchase request.
  - cancel  in  1  abort and refund.
  - sub_change  in  4  change from the external change unit (combinational).
  - sub_enable  in  1  funds-sufficient flag from the change unit.
  - total_coins  out  4  accumulated coins, to the change unit.
  - coffee_type  out  3  latched selection, to the change unit.
  - sub_confirm  out  1  change-unit confirm strobe.
  - brewing  out  1  high during brew.
  - dispense  out  1  one-cycle pulse at end of brew.
  - change_pulse  out  1  one pulse per returned coin.
  - coin_reject  out  1  one-cycle pulse per refused coin.
  - insufficient  out  1  one-cycle pulse on failed purchase.
  - busy  out  1  high in every state except IDLE and COLLECT.

Function
REQ-003 SHALL implement states IDLE, COLLECT, CHECK, BREW, PAYOUT; all outputs are registered.
REQ-004 In IDLE, coin_in SHALL set total_coins to 1 and move to COLLECT; confirm and cancel SHALL be ignored.
REQ-005 In COLLECT, coin_in SHALL increment total_coins, saturating at 15; a coin arriving at 15 SHALL pulse coin_reject the next cycle and leave the total unchanged.
REQ-006 In COLLECT, priority SHALL be cancel > coin_in > confirm; an ignored confirm has no effect and is not remembered.
REQ-007 In COLLECT, confirm with a valid coffee_sel SHALL latch coffee_type and go to CHECK; confirm with an invalid code SHALL pulse insufficient and stay in COLLECT.
REQ-008 In COLLECT, cancel SHALL load the payout counter with total_coins and go to PAYOUT.
REQ-009 CHECK SHALL last exactly one cycle with sub_confirm=1, and sub_enable and sub_change SHALL be sampled at the end of that cycle.
REQ-010 If sub_enable=1 in CHECK, the block SHALL load the payout counter with sub_change, clear total_coins and go to BREW.
REQ-011 If sub_enable=0 in CHECK, the block SHALL pulse insufficient, keep total_coins and return to COLLECT.
REQ-012 BREW SHALL hold brewing=1 for exactly BREW_CYCLES cycles, then pulse dispense for 1 cycle coincident with leaving BREW.
REQ-013 After BREW, the block SHALL go to PAYOUT if the payout counter is nonzero, otherwise to IDLE.
REQ-014 PAYOUT SHALL emit change_pulse high 1 cycle, low 1 cycle per coin, decrementing the counter on each pulse, then go to IDLE with total_coins=0 once the counter reaches 0.
REQ-015 A PAYOUT entered from cancel with a total of N SHALL produce exactly N pulses.
REQ-016 coin_in in CHECK, BREW or PAYOUT SHALL pulse coin_reject and not alter the total.
REQ-017 sub_confirm SHALL be 0 in every state except CHECK.

Reset
REQ-018 rst SHALL asynchronously force IDLE, set all counters to 0 and drive all outputs to 0, including mid-BREW and mid-PAYOUT; pending change is discarded.
REQ-019 After rst deasserts, the first rising edge SHALL behave as in IDLE.

Structure
REQ-020 Package coffee_pkg SHALL hold the state enum, coffee code constants (1..4), prices (3, 4, 5, 7) and the 4-bit coin width.
REQ-021 Saturating coin accumulation SHALL be a sub-module coin_counter (inc, clear, load, sat flag); the brew timer and payout counter SHALL be in the top module.

Verification
REQ-022 5 coins, sel=3, confirm: the bench SHALL check 1 sub_confirm cycle, brewing for 8 cycles, 1 dispense, then 2 change_pulses, then IDLE.
REQ-023 2 coins, sel=4, confirm with sub_enable=0: the bench SHALL check insufficient pulses once, state is COLLECT, and total_coins=2.
REQ-024 16 consecutive coins: the bench SHALL check total_coins=15 and exactly 1 coin_reject.
REQ-025 3 coins, then cancel and confirm in the same cycle: the bench SHALL check 3 change_pulses, no sub_confirm and no dispense.
REQ-026 rst asserted at brew cycle 4: the bench SHALL check all outputs go to 0 immediately, with no dispense and no change_pulse afterwards.
REQ-027 coin_in during BREW: the bench SHALL check one coin_reject per coin and payout unchanged.
